mod_mul_seq: RTL

Sequential modular multiplier computing c = (a * b) mod p. It uses the interleaved double-and-add method and schedules a single shared combinational mod_add instance of width LEN. It is the multiply primitive beneath the ECC point-add and point-double sequencers. It runs in constant time, independent of operand values, so there is no timing side channel.

---
 rtl/mod_mul_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier c = (a * b) mod p using interleaved double-and-add.
// It runs in constant time: every operation takes the same number of cycles, whatever the operand values.

module mod_add #(
  parameter int LEN = 8
) (
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] p,
  output logic [LEN-1:0] s
);

  logic [LEN:0] acc;

  // Both addends are below p, so at most one subtraction of p is ever needed.
  always_comb begin
    acc = {1'b0, x} + {1'b0, y};
    if (acc >= {1'b0, p}) begin
      acc = acc - {1'b0, p};
    end
    s = acc[LEN-1:0];
  end

endmodule

module mod_mul_seq #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  output logic           ready,
  output logic           done,
  output logic           err,
  output logic [LEN-1:0] c
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DBL,
    ADD,
    DONE
  } state_t;

  state_t         state, state_next;
  logic [LEN-1:0] r, r_next;
  logic [LEN-1:0] a_q, b_q, p_q;
  logic [LEN-1:0] c_q;
  logic [CW-1:0]  cnt, cnt_next;
  logic           err_q;
  logic           accept;
  logic           finish;
  logic [LEN-1:0] add_y;
  logic [LEN-1:0] add_s;

  assign accept = (state == IDLE) && start;
  assign finish = (state == ADD) && (cnt == '0);

  // In DBL the accumulator is doubled; in every other state a_q is offered for the conditional add.
  always_comb begin
    add_y = a_q;
    if (state == DBL) begin
      add_y = r;
    end
  end

  mod_add #(.LEN(LEN)) u_add (
    .x(r),
    .y(add_y),
    .p(p_q),
    .s(add_s)
  );

  always_comb begin
    state_next = state;
    r_next     = r;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DBL;
          r_next     = '0;
          cnt_next   = CW'(LEN - 1);
        end
      end
      DBL: begin
        r_next     = add_s;
        state_next = ADD;
      end
      ADD: begin
        // The adder result is always computed; only the write-back depends on the bit of b.
        if (b_q[cnt]) begin
          r_next = add_s;
        end
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next   = cnt - 1'b1;
          state_next = DBL;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      r     <= r_next;
      cnt   <= cnt_next;
    end
  end

  // Operands are captured once at accept, so the input bus is free for the rest of the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      p_q   <= p;
      err_q <= (a >= p) || (p < LEN'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else if (finish) begin
      c_q <= err_q ? '0 : r_next;
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign err   = err_q;
  assign c     = c_q;

endmodule
